// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory arbiter: FSM states, port ids, direction codes
// and default widths.
package lc3_mem_pkg;

    localparam int DATA_WIDTH_DEF     = 16;
    localparam int ADDR_WIDTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic R_W_READ  = 1'b0;
    localparam logic R_W_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin grant. On a tie the port not granted last wins; the last-grant
// pointer moves only on the update strobe.
module lc3_rr_arb2
    import lc3_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_id,
    output logic       gnt_id,
    output logic       any
);

    logic last;

    // Resetting to PORT_DATA makes the fetch port win the first tie.
    always_ff @(posedge clk) begin
        if (reset)       last <= PORT_DATA;
        else if (update) last <= upd_id;
    end

    always_comb begin
        any    = |req;
        gnt_id = PORT_FETCH;
        if (req[0] && req[1]) gnt_id = ~last;
        else if (req[1])      gnt_id = PORT_DATA;
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port LC-3 RAM.
// Optional WAIT-state timeout is enabled with `define LC3_MEM_ARBITER_TIMEOUT_EN.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  r_w0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  r_w1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_cs,
    output logic                  ram_r_w,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic                  ram_ready,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  timeout_err
);

    state_t                state, next;
    logic                  gnt_id, gnt_any;
    logic                  g_id, g_rw;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  to_hit;

    lc3_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1, req0}),
        .update (state == RESP),
        .upd_id (g_id),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

`ifdef LC3_MEM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    assign to_hit = (state == WAIT) && !ram_ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (to_hit) err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (gnt_any) next = ISSUE;
            ISSUE:   next = WAIT;
            WAIT:    if (ram_ready || to_hit) next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            g_id    <= PORT_FETCH;
            g_rw    <= 1'b0;
            g_addr  <= '0;
            g_wdata <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state <= next;
            if (state == IDLE && gnt_any) begin
                g_id    <= gnt_id;
                g_rw    <= (gnt_id == PORT_DATA) ? r_w1   : r_w0;
                g_addr  <= (gnt_id == PORT_DATA) ? addr1  : addr0;
                g_wdata <= (gnt_id == PORT_DATA) ? wdata1 : wdata0;
            end
            // A timed-out access returns zero instead of whatever is on the RAM bus.
            if (state == WAIT && (ram_ready || to_hit)) begin
                if (g_id == PORT_DATA) rdata1 <= ram_ready ? ram_data_out : '0;
                else                   rdata0 <= ram_ready ? ram_data_out : '0;
            end
        end
    end

    assign ram_cs      = (state == ISSUE);
    assign ram_r_w     = (state == ISSUE) && g_rw;
    assign ram_addr    = g_addr;
    assign ram_data_in = g_wdata;
    assign busy        = (state != IDLE);
    assign ack0        = (state == RESP) && (g_id == PORT_FETCH);
    assign ack1        = (state == RESP) && (g_id == PORT_DATA);

endmodule
